// File: rtl/dac_spi_writer.sv
// -----------------------------------------------------------------------------
// dac_spi_writer
//
// Takes the clamped output word from the output preprocessor (data/valid strobe)
// and sends it to an external SPI DAC as a {CMD, CHAN, DATA} frame, MSB first,
// SPI mode 0 (sclk idles low, DAC samples on the rising edge). Once the frame
// is complete, chip select is released and LDAC is strobed low for one cycle.
//
// One word can be held in a pending slot, so a sample that arrives while a
// frame is in flight is not lost. If the slot is already full, the newest word
// replaces it and the sticky overrun flag is set.
//
// Ports
//   clk_in          system clock
//   reset_in        asynchronous active-high reset (aborts any frame at once)
//   data_in         word to send (two's complement, sent raw)
//   data_valid_in   1-cycle strobe, data_in valid
//   overrun_clr_in  clears overrun_out (a simultaneous new overrun wins)
//   ready_out       pending slot empty
//   busy_out        serialiser not idle
//   done_out        1-cycle pulse together with the LDAC strobe
//   overrun_out     sticky, a pending word was overwritten
//   sclk_out        SPI clock
//   cs_n_out        SPI chip select, active low
//   sdi_out         SPI data to the DAC
//   ldac_n_out      DAC load strobe, active low
//
// Frame timing, in clk_in cycles:
//   CS_SETUP (setup) + 2*CLK_DIV*W_FRAME (shift) + CS_HOLD (hold) + 1 (LDAC)
// All pin outputs come straight from registers, so the DAC pins never glitch.
// -----------------------------------------------------------------------------
module dac_spi_writer #(
  parameter int               W_DATA    = 16,
  parameter int               W_CMD     = 4,
  parameter int               W_CHAN    = 4,
  parameter logic [W_CMD-1:0] CMD_WRITE = 4'h3,
  parameter int               CHAN      = 0,
  parameter int               CLK_DIV   = 2,
  parameter int               CS_SETUP  = 1,
  parameter int               CS_HOLD   = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_DATA-1:0] data_in,
  input  logic              data_valid_in,
  input  logic              overrun_clr_in,
  output logic              ready_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              overrun_out,
  output logic              sclk_out,
  output logic              cs_n_out,
  output logic              sdi_out,
  output logic              ldac_n_out
);

  localparam int W_FRAME = W_CMD + W_CHAN + W_DATA;
  localparam int W_BIT   = (W_FRAME > 1) ? $clog2(W_FRAME) : 1;

  // One counter times the setup, half-bit and hold intervals, so it has to
  // hold the largest of the three.
  localparam int CNT_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_MAX = (CNT_AB > CS_HOLD) ? CNT_AB : CS_HOLD;
  localparam int W_CNT   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [W_CNT-1:0]  DIV_LAST   = W_CNT'(CLK_DIV - 1);
  localparam logic [W_CNT-1:0]  SETUP_LAST = W_CNT'(CS_SETUP - 1);
  localparam logic [W_CNT-1:0]  HOLD_LAST  = W_CNT'(CS_HOLD - 1);
  localparam logic [W_BIT-1:0]  BIT_FIRST  = W_BIT'(W_FRAME - 1);
  localparam logic [W_CHAN-1:0] CHAN_F     = W_CHAN'(CHAN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LDAC  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [W_CNT-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;     // 0 = sclk low half, 1 = high half
  logic [W_BIT-1:0]     bit_q, bit_d;         // index of the bit on sdi
  logic [W_FRAME-1:0]   shift_q, shift_d;     // frame, frozen for its duration
  logic [W_DATA-1:0]    pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic                 overrun_q, overrun_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sdi_q, sdi_d;
  logic                 ldac_n_q, ldac_n_d;
  logic                 done_q, done_d;

  // ---------------------------------------------------------------------------
  // State register and registered pin outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sdi_q       <= 1'b0;
      ldac_n_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      sdi_q       <= sdi_d;
      ldac_n_q    <= ldac_n_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q;

    // Clear first so that an overrun detected below in the same cycle wins.
    if (overrun_clr_in) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        bit_d   = BIT_FIRST;
        if (pend_full_q) begin
          // The older pending word goes first; a word arriving now takes its
          // place in the slot.
          shift_d     = {CMD_WRITE, CHAN_F, pend_q};
          state_d     = ST_SETUP;
          pend_full_d = data_valid_in;
          if (data_valid_in) begin
            pend_d = data_in;
          end
        end else if (data_valid_in) begin
          shift_d = {CMD_WRITE, CHAN_F, data_in};
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of a high half: step to the next bit, or leave after bit 0.
            phase_d = 1'b0;
            if (bit_q == '0) begin
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q - 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_LDAC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LDAC: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any word arriving outside ST_IDLE lands in the pending slot; it never
    // touches the frame already in the shifter.
    if ((state_q != ST_IDLE) && data_valid_in) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
      if (pend_full_q) begin
        overrun_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pin values decoded from the next state, registered with it
  // ---------------------------------------------------------------------------
  always_comb begin
    sclk_d   = (state_d == ST_SHIFT) && phase_d;
    cs_n_d   = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                 (state_d == ST_HOLD));
    sdi_d    = 1'b0;
    if ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) begin
      sdi_d = shift_d[bit_d];
    end
    ldac_n_d = (state_d != ST_LDAC);
    done_d   = (state_d == ST_LDAC);
  end

  assign ready_out   = ~pend_full_q;
  assign busy_out    = (state_q != ST_IDLE);
  assign done_out    = done_q;
  assign overrun_out = overrun_q;
  assign sclk_out    = sclk_q;
  assign cs_n_out    = cs_n_q;
  assign sdi_out     = sdi_q;
  assign ldac_n_out  = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// -----------------------------------------------------------------------------
// Bench for dac_spi_writer: dut0 uses the default parameters, dut1 uses
// CLK_DIV=1, CS_SETUP=3, CS_HOLD=2. A monitor per instance samples the SPI pins
// on the falling clk edge, collects the bits seen at each sclk rise, and logs
// the frame when done_out pulses. Each test task checks its own results.
// -----------------------------------------------------------------------------
module tb_dac_spi_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data0, data1;
  logic        valid0, valid1, clr0, clr1;
  logic        ready0, busy0, done0, ovr0, sclk0, cs0, sdi0, ldac0;
  logic        ready1, busy1, done1, ovr1, sclk1, cs1, sdi1, ldac1;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_writer dut0 (
    .clk_in(clk), .reset_in(rst), .data_in(data0), .data_valid_in(valid0),
    .overrun_clr_in(clr0), .ready_out(ready0), .busy_out(busy0),
    .done_out(done0), .overrun_out(ovr0), .sclk_out(sclk0), .cs_n_out(cs0),
    .sdi_out(sdi0), .ldac_n_out(ldac0)
  );

  dac_spi_writer #(.CLK_DIV(1), .CS_SETUP(3), .CS_HOLD(2)) dut1 (
    .clk_in(clk), .reset_in(rst), .data_in(data1), .data_valid_in(valid1),
    .overrun_clr_in(clr1), .ready_out(ready1), .busy_out(busy1),
    .done_out(done1), .overrun_out(ovr1), .sclk_out(sclk1), .cs_n_out(cs1),
    .sdi_out(sdi1), .ldac_n_out(ldac1)
  );

  // ---------------- monitor for dut0 ----------------
  logic        m0_pcs = 1'b1, m0_psclk = 1'b0;
  logic [23:0] m0_frame = '0;
  int          m0_bits = 0, m0_fall = 0;
  logic [23:0] q_frame[$];
  int          q_bits[$], q_fall[$], q_done[$];
  logic        q_ldac[$];

  always @(negedge clk) begin
    if (m0_pcs && !cs0) begin
      m0_frame <= '0;
      m0_bits  <= 0;
      m0_fall  <= cyc;
    end else if (!m0_psclk && sclk0) begin
      m0_frame <= {m0_frame[22:0], sdi0};
      m0_bits  <= m0_bits + 1;
    end
    if (done0) begin
      q_frame.push_back(m0_frame);
      q_bits.push_back(m0_bits);
      q_fall.push_back(m0_fall);
      q_done.push_back(cyc);
      q_ldac.push_back(ldac0);
    end
    m0_pcs   <= cs0;
    m0_psclk <= sclk0;
  end

  // ---------------- monitor for dut1 (also checks phase lengths) ----------------
  logic        m1_pcs = 1'b1, m1_psclk = 1'b0;
  logic [23:0] m1_frame = '0;
  int          m1_bits = 0, m1_fall = 0, m1_first = 0, m1_rise = 0;
  int          m1_bad = 0, m1_done = 0, m1_ndone = 0;

  always @(negedge clk) begin
    if (m1_pcs && !cs1) begin
      m1_frame <= '0;
      m1_bits  <= 0;
      m1_fall  <= cyc;
    end else if (!m1_psclk && sclk1) begin
      m1_frame <= {m1_frame[22:0], sdi1};
      m1_bits  <= m1_bits + 1;
      if (m1_bits == 0) m1_first <= cyc;
      else if (cyc - m1_rise != 2) m1_bad <= m1_bad + 1;
      m1_rise <= cyc;
    end else if (m1_psclk && !sclk1) begin
      if (cyc - m1_rise != 1) m1_bad <= m1_bad + 1;
    end
    if (done1) begin
      m1_done  <= cyc;
      m1_ndone <= m1_ndone + 1;
    end
    m1_pcs   <= cs1;
    m1_psclk <= sclk1;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  // Called just after a falling edge; returns the cycle number of the rising
  // edge that sampled the strobe.
  task automatic send0(input logic [15:0] d, output int c);
    data0  = d;
    valid0 = 1'b1;
    @(negedge clk);
    c      = cyc;
    valid0 = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_frames0(input int n, output bit ok);
    int k = 0;
    while (q_frame.size() < n && k < 120 * n + 100) begin
      @(negedge clk);
      k++;
    end
    ok = (q_frame.size() >= n);
    @(negedge clk);
  endtask

  task automatic clr_pulse0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (cs0 !== 1'b1)    begin n_bad++; $display("FAIL rst_cs_n got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b0)  begin n_bad++; $display("FAIL rst_sclk got %b want 0", sclk0); end
    n_cmp++; if (sdi0 !== 1'b0)   begin n_bad++; $display("FAIL rst_sdi got %b want 0", sdi0); end
    n_cmp++; if (ldac0 !== 1'b1)  begin n_bad++; $display("FAIL rst_ldac_n got %b want 1", ldac0); end
    n_cmp++; if (done0 !== 1'b0)  begin n_bad++; $display("FAIL rst_done got %b want 0", done0); end
    n_cmp++; if (ovr0 !== 1'b0)   begin n_bad++; $display("FAIL rst_overrun got %b want 0", ovr0); end
    n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", ready0); end
    n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL rst_busy got %b want 0", busy0); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL idle_after_rst busy got %b want 0", busy0); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int c;
    bit ok;
    q_frame.delete(); q_bits.delete(); q_fall.delete(); q_done.delete(); q_ldac.delete();
    send0(16'h8001, c);
    n_cmp++; if (cs0 !== 1'b0) begin n_bad++; $display("FAIL single_cs_fall got %b want 0", cs0); end
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy0); end
    wait_frames0(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout frames %0d want 1", q_frame.size()); end
    n_cmp++; if (q_frame[0] !== 24'h308001) begin n_bad++; $display("FAIL single_frame got %h want 308001", q_frame[0]); end
    n_cmp++; if (q_bits[0] !== 24) begin n_bad++; $display("FAIL single_sclk_pulses got %0d want 24", q_bits[0]); end
    n_cmp++; if (q_fall[0] !== c) begin n_bad++; $display("FAIL single_cs_cycle got %0d want %0d", q_fall[0], c); end
    n_cmp++; if (q_done[0] - c !== 98) begin n_bad++; $display("FAIL single_ldac_latency got %0d want 98", q_done[0] - c); end
    n_cmp++; if (q_ldac[0] !== 1'b0) begin n_bad++; $display("FAIL single_ldac_low got %b want 0", q_ldac[0]); end
    n_cmp++; if (cs0 !== 1'b1 || busy0 !== 1'b0) begin n_bad++; $display("FAIL single_end cs %b busy %b want 1 0", cs0, busy0); end
    $display("test_single frame %h len %0d", q_frame[0], q_done[0] - q_fall[0] + 1);
  endtask

  task automatic test_pending();
    int c, c2;
    bit ok;
    q_frame.delete(); q_bits.delete(); q_fall.delete(); q_done.delete(); q_ldac.delete();
    send0(16'hABCD, c);
    wait_until(c + 40);
    send0(16'h1234, c2);
    n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL pend_ready got %b want 0", ready0); end
    wait_frames0(2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pend_timeout frames %0d want 2", q_frame.size()); end
    n_cmp++; if (q_frame[0] !== 24'h30ABCD) begin n_bad++; $display("FAIL pend_frame0 got %h want 30abcd", q_frame[0]); end
    n_cmp++; if (q_frame[1] !== 24'h301234) begin n_bad++; $display("FAIL pend_frame1 got %h want 301234", q_frame[1]); end
    n_cmp++; if (q_fall[1] - q_done[0] !== 2) begin n_bad++; $display("FAIL pend_gap got %0d want 2", q_fall[1] - q_done[0]); end
    n_cmp++; if (q_done[1] - q_fall[1] !== 98) begin n_bad++; $display("FAIL pend_len got %0d want 98", q_done[1] - q_fall[1]); end
    n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL pend_overrun got %b want 0", ovr0); end
    n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL pend_ready_end got %b want 1", ready0); end
    $display("test_pending frames %h %h", q_frame[0], q_frame[1]);
  endtask

  task automatic test_overrun();
    int c, c2;
    bit ok;
    q_frame.delete(); q_bits.delete(); q_fall.delete(); q_done.delete(); q_ldac.delete();
    send0(16'h1111, c);
    wait_until(c + 20);
    send0(16'h2222, c2);
    n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL ovr_first_pend got %b want 0", ovr0); end
    wait_until(c + 30);
    send0(16'h3333, c2);
    n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", ovr0); end
    wait_frames0(2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovr_timeout frames %0d want 2", q_frame.size()); end
    n_cmp++; if (q_frame[0] !== 24'h301111) begin n_bad++; $display("FAIL ovr_frameA got %h want 301111", q_frame[0]); end
    n_cmp++; if (q_frame[1] !== 24'h303333) begin n_bad++; $display("FAIL ovr_frameC got %h want 303333", q_frame[1]); end
    n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", ovr0); end
    clr_pulse0();
    n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %b want 0", ovr0); end
    // clear and a new overrun in the same cycle
    send0(16'h4444, c);
    wait_until(c + 10);
    send0(16'h5555, c2);
    wait_until(c + 20);
    data0 = 16'h6666; valid0 = 1'b1; clr0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0; clr0 = 1'b0;
    n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_clr_vs_set got %b want 1", ovr0); end
    wait_frames0(4, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovr_timeout2 frames %0d want 4", q_frame.size()); end
    n_cmp++; if (q_frame[3] !== 24'h306666) begin n_bad++; $display("FAIL ovr_frameF got %h want 306666", q_frame[3]); end
    clr_pulse0();
    n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL ovr_clear2 got %b want 0", ovr0); end
    $display("test_overrun frames %0d", q_frame.size());
  endtask

  task automatic test_ldac_valid();
    int c, c2, d, k;
    bit ok;
    q_frame.delete(); q_bits.delete(); q_fall.delete(); q_done.delete(); q_ldac.delete();
    send0(16'h0F0F, c);
    k = 0;
    while (done0 !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL ldacv_done_seen got %b want 1", done0); end
    d = cyc;
    send0(16'h7777, c2);
    n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL ldacv_pending got %b want 0", ready0); end
    wait_frames0(2, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ldacv_timeout frames %0d want 2", q_frame.size()); end
    n_cmp++; if (q_frame[1] !== 24'h307777) begin n_bad++; $display("FAIL ldacv_frame got %h want 307777", q_frame[1]); end
    n_cmp++; if (q_fall[1] - d !== 2) begin n_bad++; $display("FAIL ldacv_gap got %0d want 2", q_fall[1] - d); end
    $display("test_ldac_valid frame %h", q_frame[1]);
  endtask

  task automatic test_reset_mid();
    int c;
    q_frame.delete(); q_bits.delete(); q_fall.delete(); q_done.delete(); q_ldac.delete();
    send0(16'hFFFF, c);
    wait_until(c + 55);   // high half of frame bit 10
    n_cmp++; if (sclk0 !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_sclk got %b want 1", sclk0); end
    n_cmp++; if (sdi0 !== 1'b1)  begin n_bad++; $display("FAIL rmid_pre_sdi got %b want 1", sdi0); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cs0 !== 1'b1)   begin n_bad++; $display("FAIL rmid_cs_n got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_bad++; $display("FAIL rmid_sclk got %b want 0", sclk0); end
    n_cmp++; if (sdi0 !== 1'b0)  begin n_bad++; $display("FAIL rmid_sdi got %b want 0", sdi0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy0); end
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    n_cmp++; if (q_frame.size() !== 0) begin n_bad++; $display("FAIL rmid_no_frame got %0d want 0", q_frame.size()); end
    n_cmp++; if (cs0 !== 1'b1 || busy0 !== 1'b0) begin n_bad++; $display("FAIL rmid_idle cs %b busy %b want 1 0", cs0, busy0); end
    $display("test_reset_mid frames after release %0d", q_frame.size());
  endtask

  task automatic test_clkdiv1();
    int c, n0, k;
    n0 = m1_ndone;
    data1  = 16'hC3A5;
    valid1 = 1'b1;
    @(negedge clk);
    c      = cyc;
    valid1 = 1'b0;
    n_cmp++; if (cs1 !== 1'b0) begin n_bad++; $display("FAIL cd1_cs_fall got %b want 0", cs1); end
    k = 0;
    while (m1_ndone == n0 && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    n_cmp++; if (m1_ndone !== n0 + 1) begin n_bad++; $display("FAIL cd1_done_count got %0d want %0d", m1_ndone, n0 + 1); end
    n_cmp++; if (m1_frame !== 24'h30C3A5) begin n_bad++; $display("FAIL cd1_frame got %h want 30c3a5", m1_frame); end
    n_cmp++; if (m1_bits !== 24) begin n_bad++; $display("FAIL cd1_pulses got %0d want 24", m1_bits); end
    n_cmp++; if (m1_fall !== c) begin n_bad++; $display("FAIL cd1_cs_cycle got %0d want %0d", m1_fall, c); end
    n_cmp++; if (m1_done - m1_fall + 1 !== 54) begin n_bad++; $display("FAIL cd1_len got %0d want 54", m1_done - m1_fall + 1); end
    n_cmp++; if (m1_first - m1_fall !== 4) begin n_bad++; $display("FAIL cd1_first_rise got %0d want 4", m1_first - m1_fall); end
    n_cmp++; if (m1_bad !== 0) begin n_bad++; $display("FAIL cd1_phase_errors got %0d want 0", m1_bad); end
    $display("test_clkdiv1 frame %h len %0d", m1_frame, m1_done - m1_fall + 1);
  endtask

  initial begin
    rst = 1'b1;
    data0 = '0; data1 = '0;
    valid0 = 1'b0; valid1 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_pending();
    test_overrun();
    test_ldac_valid();
    test_reset_mid();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
